// File: rtl/sifh_acq_scheduler_pkg.sv
// Shared defaults, FSM state encoding and counter-width helper for the SiFH acquisition scheduler.
package sifh_acq_scheduler_pkg;

  localparam int NP_DEF        = 16;
  localparam int DATA_NUM_DEF  = 4;
  localparam int PIXEL_NUM_DEF = 8;
  localparam int ACQ_NUM_DEF   = 33333;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_COARSE = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_FINE   = 3'd4,
    ST_DONE   = 3'd5
  } sched_state_e;

  // A limit of 1 still gets a 1-bit counter that simply never leaves 0.
  function automatic int cnt_w(input int limit);
    return (limit <= 1) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/sifh_acq_scheduler_seq_counter.sv
// Cascaded data -> pixel -> acquisition counter; advances once per enabled cycle.
module sifh_seq_counter
  import sifh_acq_scheduler_pkg::*;
#(
  parameter int DATA_NUM  = DATA_NUM_DEF,
  parameter int PIXEL_NUM = PIXEL_NUM_DEF,
  parameter int ACQ_NUM   = ACQ_NUM_DEF
) (
  input  logic                          clk_i,
  input  logic                          res_i,
  input  logic                          clr_i,
  input  logic                          en_i,
  output logic [cnt_w(DATA_NUM)-1:0]    data_cnt_o,
  output logic [cnt_w(PIXEL_NUM)-1:0]   pixel_cnt_o,
  output logic [cnt_w(ACQ_NUM)-1:0]     acq_cnt_o,
  output logic                          last_o
);

  localparam int DW = cnt_w(DATA_NUM);
  localparam int PW = cnt_w(PIXEL_NUM);
  localparam int AW = cnt_w(ACQ_NUM);
  localparam logic [DW-1:0] D_MAX = DW'(DATA_NUM - 1);
  localparam logic [PW-1:0] P_MAX = PW'(PIXEL_NUM - 1);
  localparam logic [AW-1:0] A_MAX = AW'(ACQ_NUM - 1);

  logic [DW-1:0] data_q, data_d;
  logic [PW-1:0] pixel_q, pixel_d;
  logic [AW-1:0] acq_q, acq_d;
  logic          d_wrap, p_wrap, a_wrap;

  assign d_wrap = (data_q == D_MAX);
  assign p_wrap = (pixel_q == P_MAX);
  assign a_wrap = (acq_q == A_MAX);

  always_comb begin
    data_d  = data_q;
    pixel_d = pixel_q;
    acq_d   = acq_q;
    if (clr_i) begin
      data_d  = '0;
      pixel_d = '0;
      acq_d   = '0;
    end else if (en_i) begin
      if (d_wrap) begin
        data_d = '0;
        if (p_wrap) begin
          pixel_d = '0;
          acq_d   = a_wrap ? '0 : acq_q + 1'b1;
        end else begin
          pixel_d = pixel_q + 1'b1;
        end
      end else begin
        data_d = data_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      data_q  <= '0;
      pixel_q <= '0;
      acq_q   <= '0;
    end else begin
      data_q  <= data_d;
      pixel_q <= pixel_d;
      acq_q   <= acq_d;
    end
  end

  assign data_cnt_o  = data_q;
  assign pixel_cnt_o = pixel_q;
  assign acq_cnt_o   = acq_q;
  // Whole-pass wrap: every stage sits at its maximum.
  assign last_o      = d_wrap & p_wrap & a_wrap;

endmodule

// File: rtl/sifh_acq_scheduler.sv
// Two-pass frame sequencer: admits TDC samples from the pixel-owning lane in strict order
// and drives the histogram builder's write, data and clear strobes.
module sifh_acq_scheduler
  import sifh_acq_scheduler_pkg::*;
#(
  parameter int NP         = NP_DEF,
  parameter int NUM_REQ    = 2,
  parameter int DATA_NUM   = DATA_NUM_DEF,
  parameter int PIXEL_NUM  = PIXEL_NUM_DEF,
  parameter int ACQ_NUM    = ACQ_NUM_DEF,
  parameter int CLR_CYCLES = 4,
  parameter int PEAK_LAT   = 3
) (
  input  logic                          clk,
  input  logic                          res,
  input  logic                          start,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*NP-1:0]         req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          hb_wr_en,
  output logic [NP-1:0]                 hb_data,
  output logic                          hb_clr,
  output logic                          pass_fine,
  output logic [cnt_w(PIXEL_NUM)-1:0]   pixel_idx,
  output logic                          busy,
  output logic                          frame_done,
  output sched_state_e                  dbg_state
);

  localparam int PW       = cnt_w(PIXEL_NUM);
  // FLUSH spans the last-write cycle plus PEAK_LAT quiet cycles before clear starts.
  localparam int WAIT_MAX = (CLR_CYCLES > PEAK_LAT + 1) ? CLR_CYCLES : PEAK_LAT + 1;
  localparam int WW       = cnt_w(WAIT_MAX);
  localparam logic [WW-1:0] CLR_LAST   = WW'(CLR_CYCLES - 1);
  localparam logic [WW-1:0] FLUSH_LAST = WW'(PEAK_LAT);

  sched_state_e                state_q;
  logic [WW-1:0]               wait_q;
  logic                        hb_wr_en_q, hb_clr_q, pass_fine_q, frame_done_q;
  logic [NP-1:0]               hb_data_q;
  logic [PW-1:0]               pixel_idx_q;

  logic [cnt_w(DATA_NUM)-1:0]  data_cnt;
  logic [PW-1:0]               pixel_cnt;
  logic [cnt_w(ACQ_NUM)-1:0]   acq_cnt;
  logic                        seq_last, in_pass, accept, cnt_clr;
  logic [NUM_REQ-1:0]          ready;
  logic [NP-1:0]               sel_data;
  logic [31:0]                 owner;

  // Handshake: a lane transfers when valid & ready are both high at a rising edge.
  // Ready depends only on registered state, never on valid, and only the lane owning
  // the current pixel is ever ready; other lanes are held off, not dropped.
  assign in_pass = (state_q == ST_COARSE) || (state_q == ST_FINE);
  assign accept  = |(req_valid & ready);
  assign cnt_clr = (state_q == ST_IDLE) && start;

  always_comb begin
    ready    = '0;
    sel_data = '0;
    owner    = 32'(pixel_cnt) % 32'(NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner == 32'(i)) begin
        ready[i] = in_pass;
        sel_data = req_data[i*NP +: NP];
      end
    end
  end

  sifh_seq_counter #(
    .DATA_NUM  (DATA_NUM),
    .PIXEL_NUM (PIXEL_NUM),
    .ACQ_NUM   (ACQ_NUM)
  ) u_seq_counter (
    .clk_i       (clk),
    .res_i       (res),
    .clr_i       (cnt_clr),
    .en_i        (accept),
    .data_cnt_o  (data_cnt),
    .pixel_cnt_o (pixel_cnt),
    .acq_cnt_o   (acq_cnt),
    .last_o      (seq_last)
  );

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      hb_wr_en_q   <= 1'b0;
      hb_data_q    <= '0;
      hb_clr_q     <= 1'b0;
      pass_fine_q  <= 1'b0;
      pixel_idx_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      hb_wr_en_q   <= accept;
      frame_done_q <= 1'b0;
      pixel_idx_q  <= pixel_cnt;
      if (accept) hb_data_q <= sel_data;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_CLEAR;
            hb_clr_q    <= 1'b1;
            pass_fine_q <= 1'b0;
            wait_q      <= '0;
          end
        end
        ST_CLEAR: begin
          if (wait_q == CLR_LAST) begin
            wait_q   <= '0;
            hb_clr_q <= 1'b0;
            state_q  <= pass_fine_q ? ST_FINE : ST_COARSE;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_COARSE: if (accept && seq_last) state_q <= ST_FLUSH;
        ST_FLUSH: begin
          if (wait_q == FLUSH_LAST) begin
            wait_q      <= '0;
            pass_fine_q <= 1'b1;
            hb_clr_q    <= 1'b1;
            state_q     <= ST_CLEAR;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        ST_FINE: if (accept && seq_last) state_q <= ST_DONE;
        ST_DONE: begin
          frame_done_q <= 1'b1;
          pass_fine_q  <= 1'b0;
          state_q      <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = ready;
  assign hb_wr_en   = hb_wr_en_q;
  assign hb_data    = hb_data_q;
  assign hb_clr     = hb_clr_q;
  assign pass_fine  = pass_fine_q;
  assign pixel_idx  = pixel_idx_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_sifh_acq_scheduler.sv
// Bench for sifh_acq_scheduler: ordered frames, stalls, ignored start, mid-frame reset, small-parameter sweep.
`timescale 1ns/1ps
module tb_sifh_acq_scheduler;
  import sifh_acq_scheduler_pkg::*;

  localparam int NP = 16, NUM_REQ = 2, DATA_NUM = 2, PIXEL_NUM = 4, ACQ_NUM = 3;
  localparam int CLR_CYCLES = 4, PEAK_LAT = 3;
  localparam int PASS_WR = DATA_NUM * PIXEL_NUM * ACQ_NUM;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0, res = 1'b1, start = 1'b0, s_start = 1'b0;
  logic [NUM_REQ-1:0]    req_valid = '0, s_valid = '0;
  logic [NUM_REQ*NP-1:0] req_data = '0, s_data = '0;
  logic [NUM_REQ-1:0]    req_ready, s_ready;
  logic hb_wr_en, hb_clr, pass_fine, busy, frame_done;
  logic s_wr_en, s_clr, s_pass_fine, s_busy, s_frame_done;
  logic [NP-1:0] hb_data, s_hb_data;
  logic [1:0] pixel_idx, s_pixel_idx;
  sched_state_e dbg_state, s_state;

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  sifh_acq_scheduler #(.NP(NP), .NUM_REQ(NUM_REQ), .DATA_NUM(DATA_NUM), .PIXEL_NUM(PIXEL_NUM),
    .ACQ_NUM(ACQ_NUM), .CLR_CYCLES(CLR_CYCLES), .PEAK_LAT(PEAK_LAT)) dut (
    .clk(clk), .res(res), .start(start), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .hb_wr_en(hb_wr_en), .hb_data(hb_data), .hb_clr(hb_clr),
    .pass_fine(pass_fine), .pixel_idx(pixel_idx), .busy(busy), .frame_done(frame_done),
    .dbg_state(dbg_state));

  sifh_acq_scheduler #(.NP(NP), .NUM_REQ(NUM_REQ), .DATA_NUM(1), .PIXEL_NUM(PIXEL_NUM),
    .ACQ_NUM(1), .CLR_CYCLES(CLR_CYCLES), .PEAK_LAT(PEAK_LAT)) dut_s (
    .clk(clk), .res(res), .start(s_start), .req_valid(s_valid), .req_data(s_data),
    .req_ready(s_ready), .hb_wr_en(s_wr_en), .hb_data(s_hb_data), .hb_clr(s_clr),
    .pass_fine(s_pass_fine), .pixel_idx(s_pixel_idx), .busy(s_busy), .frame_done(s_frame_done),
    .dbg_state(s_state));

  // ---------------- scoreboard ----------------
  int n_checks = 0, n_fail = 0;
  logic [18:0] exp_q[$];
  logic [18:0] exp_s_q[$];
  logic [18:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  int wr_cnt, done_cnt, done_cyc, last_wr_cyc, last_coarse_wr_cyc, first_wr_cyc, first_fine_wr_cyc;
  int clr_cnt, n_rise;
  int clr_rise[4];
  logic prev_clr = 1'b0;

  task automatic reset_stats();
    wr_cnt = 0; done_cnt = 0; done_cyc = -1; last_wr_cyc = -1; last_coarse_wr_cyc = -1;
    first_wr_cyc = -1; first_fine_wr_cyc = -1; clr_cnt = 0; n_rise = 0;
    for (int i = 0; i < 4; i++) clr_rise[i] = -1;
  endtask

  always @(negedge clk) begin
    if (hb_wr_en) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (!pass_fine) last_coarse_wr_cyc = cyc;
      else if (first_fine_wr_cyc < 0) first_fine_wr_cyc = cyc;
      if (exp_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("hb_data", 32'(hb_data), 32'(mon_e[15:0]));
        check("pixel_idx", 32'(pixel_idx), 32'(mon_e[17:16]));
        check("pass_fine", 32'(pass_fine), 32'(mon_e[18]));
      end
    end
    if (hb_clr) begin
      clr_cnt++;
      if (!prev_clr) begin
        if (n_rise < 4) clr_rise[n_rise] = cyc;
        n_rise++;
      end
    end
    prev_clr = hb_clr;
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] data;
    int          lane;
    logic [1:0]  pix;
    logic        fine;
  } vec_t;
  vec_t vecs[2*PASS_WR];

  // ---------------- driver tasks ----------------
  task automatic send(input int lane, input logic [15:0] val, input logic [1:0] pix, input logic fine);
    int budget;
    req_valid = '1;
    for (int l = 0; l < NUM_REQ; l++) req_data[l*NP +: NP] = (l == lane) ? val : (16'hBAD0 + 16'(l));
    exp_q.push_back({fine, pix, val});
    budget = 0;
    while (!req_ready[lane] && budget < 200) begin
      @(negedge clk);
      budget++;
    end
    if (!req_ready[lane]) begin
      check("send_timeout", 32'd0, 32'd1);
      void'(exp_q.pop_back());
    end else begin
      check("ready_onehot", 32'(req_ready), 32'(1) << lane);
      @(negedge clk);
    end
  endtask

  task automatic do_stall(input int lane);
    req_valid = '1;
    req_valid[lane] = 1'b0;
    @(negedge clk);
    for (int j = 0; j < 4; j++) begin
      check("stall_no_write", 32'(hb_wr_en), 32'd0);
      check("stall_ready", 32'(req_ready), 32'(1) << lane);
      @(negedge clk);
    end
  endtask

  task automatic begin_frame(output int s);
    @(negedge clk);
    #1;
    reset_stats();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    s = cyc;
    check("start_busy", 32'(busy), 32'd1);
    check("start_hb_clr", 32'(hb_clr), 32'd1);
    check("start_state", 32'(dbg_state), 32'(ST_CLEAR));
    check("start_ready", 32'(req_ready), 32'd0);
    check("start_pixel_idx", 32'(pixel_idx), 32'd0);
  endtask

  task automatic run_frame(input int stall_idx, input int pulse_idx, input int stop_idx);
    for (int k = 0; k < stop_idx; k++) begin
      if (k == stall_idx) do_stall(vecs[k].lane);
      start = (k == pulse_idx);
      send(vecs[k].lane, vecs[k].data, vecs[k].pix, vecs[k].fine);
      start = 1'b0;
      if (k == pulse_idx) check("pulse_ignored_state", 32'(dbg_state), 32'(ST_COARSE));
    end
  endtask

  task automatic finish_frame(input int s, input bit absolute);
    int t;
    t = 0;
    #1;
    while (done_cnt == 0 && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("frame_done_seen", 32'(done_cnt > 0), 32'd1);
    req_valid = '0;
    repeat (3) @(negedge clk);
    #1;
    check("wr_count", 32'(wr_cnt), 32'(2*PASS_WR));
    check("clr_cycles", 32'(clr_cnt), 32'(2*CLR_CYCLES));
    check("clr_rises", 32'(n_rise), 32'd2);
    if (absolute) begin
      check("first_clr_cyc", 32'(clr_rise[0]), 32'(s));
      check("first_wr_cyc", 32'(first_wr_cyc), 32'(s + CLR_CYCLES + 1));
    end
    check("flush_gap", 32'(clr_rise[1] - last_coarse_wr_cyc), 32'(PEAK_LAT + 1));
    check("fine_start", 32'(first_fine_wr_cyc - clr_rise[1]), 32'(CLR_CYCLES + 1));
    check("fine_span", 32'(last_wr_cyc - first_fine_wr_cyc), 32'(PASS_WR - 1));
    check("done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_state", 32'(dbg_state), 32'(ST_IDLE));
    check("idle_pass_fine", 32'(pass_fine), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int s, t, sw_wr;
    logic sw_done, sw_prev_wr;
    logic [18:0] se;

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < PASS_WR; i++) begin
        vecs[f*PASS_WR+i].data = 16'(i + 1);
        vecs[f*PASS_WR+i].pix  = 2'((i / DATA_NUM) % PIXEL_NUM);
        vecs[f*PASS_WR+i].lane = ((i / DATA_NUM) % PIXEL_NUM) % NUM_REQ;
        vecs[f*PASS_WR+i].fine = (f == 1);
      end
    end
    reset_stats();

    // reset state
    repeat (2) @(negedge clk);
    check("rst_wr_en", 32'(hb_wr_en), 32'd0);
    check("rst_hb_data", 32'(hb_data), 32'd0);
    check("rst_hb_clr", 32'(hb_clr), 32'd0);
    check("rst_pass_fine", 32'(pass_fine), 32'd0);
    check("rst_pixel_idx", 32'(pixel_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    res = 1'b0;
    repeat (2) @(negedge clk);

    // frame A: both lanes always valid, sequential data, absolute timing
    begin_frame(s);
    run_frame(-1, -1, 2*PASS_WR);
    finish_frame(s, 1'b1);

    // frame B: lane 1 stalled at pixel 1, start pulsed mid coarse pass
    begin_frame(s);
    run_frame(2, 12, 2*PASS_WR);
    finish_frame(s, 1'b0);

    // frame C: reset after the 10th coarse write, with the 11th in flight
    begin_frame(s);
    run_frame(-1, -1, 10);
    #2 res = 1'b1;
    #1;
    check("mid_rst_wr_en", 32'(hb_wr_en), 32'd0);
    check("mid_rst_hb_data", 32'(hb_data), 32'd0);
    check("mid_rst_hb_clr", 32'(hb_clr), 32'd0);
    check("mid_rst_pixel_idx", 32'(pixel_idx), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    res = 1'b0;
    req_valid = '0;
    repeat (4) @(negedge clk);
    #1;
    check("mid_rst_writes", 32'(wr_cnt), 32'd10);
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    check("mid_rst_sb_empty", 32'(exp_q.size()), 32'd0);

    // frame D: clean restart after reset
    begin_frame(s);
    run_frame(-1, -1, 2*PASS_WR);
    finish_frame(s, 1'b1);

    // sweep: DATA_NUM=1, ACQ_NUM=1 -> 4 writes per pass
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < PIXEL_NUM; p++)
        exp_s_q.push_back({f[0], 2'(p), (p % 2 == 1) ? 16'h00B1 : 16'h00A0});
    s_valid = '1;
    s_data = {16'h00B1, 16'h00A0};
    @(negedge clk);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    sw_wr = 0;
    sw_done = 1'b0;
    sw_prev_wr = 1'b0;
    t = 0;
    while (!sw_done && t < 80) begin
      if (s_frame_done) begin
        sw_done = 1'b1;
        check("sweep_writes_before_done", 32'(sw_wr), 32'd8);
        check("sweep_done_after_last_wr", 32'(sw_prev_wr), 32'd1);
      end
      if (s_wr_en) begin
        sw_wr++;
        if (exp_s_q.size() == 0) check("sweep_unexpected_write", 32'd1, 32'd0);
        else begin
          se = exp_s_q.pop_front();
          check("sweep_hb_data", 32'(s_hb_data), 32'(se[15:0]));
          check("sweep_pixel_idx", 32'(s_pixel_idx), 32'(se[17:16]));
          check("sweep_pass_fine", 32'(s_pass_fine), 32'(se[18]));
        end
      end
      sw_prev_wr = s_wr_en;
      @(negedge clk);
      t++;
    end
    check("sweep_done_seen", 32'(sw_done), 32'd1);
    s_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
